// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID->EX pipeline register with valid/ready handshake, EX/MEM and
//             MEM/WB operand forwarding, load-use bubbles and branch flush.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  // ID side
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [3:0]            in_alu_ctr,
  input  logic [1:0]            in_asrc,
  input  logic                  in_bsrc,
  input  logic                  flush,
  // bypass network
  input  logic                  exm_valid,
  input  logic                  exm_wen,
  input  logic                  exm_is_load,
  input  logic [REG_AW-1:0]     exm_rd,
  input  logic [DATA_WIDTH-1:0] exm_result,
  input  logic                  wb_valid,
  input  logic                  wb_wen,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_result,
  // EX side
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctr,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_store_data,
  output logic [REG_AW-1:0]     ex_rd,
  output logic                  ex_rd_wen,
  output logic                  ex_is_load
);

  localparam logic [1:0] C_ASRC_RS1 = 2'd0;
  localparam logic [1:0] C_ASRC_PC  = 2'd1;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] pc_q, rs1_val_q, rs2_val_q, imm_q;
  logic [REG_AW-1:0]     rs1_q, rs2_q, rd_q;
  logic                  use_rs1_q, use_rs2_q, rd_wen_q, is_load_q, bsrc_q;
  logic [3:0]            alu_ctr_q;
  logic [1:0]            asrc_q;

  logic [DATA_WIDTH-1:0] fwd_rs1_d, fwd_rs2_d;
  logic                  exm_fwd_ok, wb_fwd_ok, exm_load_pending;
  logic                  load_use, fire_in, fire_out;

  // A load in EX/MEM has no data yet, so it may only stall, never forward.
  assign exm_fwd_ok       = exm_valid & exm_wen & ~exm_is_load;
  assign exm_load_pending = exm_valid & exm_wen & exm_is_load;
  assign wb_fwd_ok        = wb_valid & wb_wen;

  // Bypass mux per source: EX/MEM beats MEM/WB beats stored value; x0 never forwarded.
  always_comb begin
    fwd_rs1_d = rs1_val_q;
    if (exm_fwd_ok && exm_rd == rs1_q && rs1_q != '0)
      fwd_rs1_d = exm_result;
    else if (wb_fwd_ok && wb_rd == rs1_q && rs1_q != '0)
      fwd_rs1_d = wb_result;

    fwd_rs2_d = rs2_val_q;
    if (exm_fwd_ok && exm_rd == rs2_q && rs2_q != '0)
      fwd_rs2_d = exm_result;
    else if (wb_fwd_ok && wb_rd == rs2_q && rs2_q != '0)
      fwd_rs2_d = wb_result;
  end

  // Bubble while a source actually read waits on a load still in EX/MEM.
  assign load_use = valid_q & exm_load_pending &
                    ((use_rs1_q & (exm_rd == rs1_q) & (rs1_q != '0)) |
                     (use_rs2_q & (exm_rd == rs2_q) & (rs2_q != '0)));

  assign out_valid = valid_q & ~load_use;
  assign fire_out  = out_valid & out_ready;
  assign in_ready  = ~valid_q | fire_out;
  assign fire_in   = in_valid & in_ready & ~flush;

  // Operand A select: rs1, PC or zero.
  always_comb begin
    alu_a = '0;
    case (asrc_q)
      C_ASRC_RS1: alu_a = fwd_rs1_d;
      C_ASRC_PC:  alu_a = pc_q;
      default:    alu_a = '0;
    endcase
  end

  assign alu_b         = bsrc_q ? imm_q : fwd_rs2_d;
  assign ex_store_data = fwd_rs2_d;
  assign alu_ctr       = alu_ctr_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_rd_wen     = rd_wen_q;
  assign ex_is_load    = is_load_q;

  // Pipeline register: flush > accept > issue > sticky operand refresh while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      rd_q      <= '0;
      rd_wen_q  <= 1'b0;
      is_load_q <= 1'b0;
      alu_ctr_q <= 4'b0000;
      asrc_q    <= 2'b00;
      bsrc_q    <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fire_in) begin
      valid_q   <= 1'b1;
      pc_q      <= in_pc;
      rs1_q     <= in_rs1;
      rs2_q     <= in_rs2;
      rs1_val_q <= in_rs1_val;
      rs2_val_q <= in_rs2_val;
      imm_q     <= in_imm;
      use_rs1_q <= in_use_rs1;
      use_rs2_q <= in_use_rs2;
      rd_q      <= in_rd;
      rd_wen_q  <= in_rd_wen;
      is_load_q <= in_is_load;
      alu_ctr_q <= in_alu_ctr;
      asrc_q    <= in_asrc;
      bsrc_q    <= in_bsrc;
    end else if (fire_out) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      rs1_val_q <= fwd_rs1_d;
      rs2_val_q <= fwd_rs2_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Directed self-checking bench for id_ex_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_use_rs1, in_use_rs2, in_rd_wen, in_is_load, in_bsrc, flush;
  logic [3:0]    in_alu_ctr;
  logic [1:0]    in_asrc;
  logic          exm_valid, exm_wen, exm_is_load, wb_valid, wb_wen;
  logic [AW-1:0] exm_rd, wb_rd;
  logic [DW-1:0] exm_result, wb_result;
  logic          out_valid, out_ready, ex_rd_wen, ex_is_load;
  logic [DW-1:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [3:0]    alu_ctr;
  logic [AW-1:0] ex_rd;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.DATA_WIDTH(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
    .in_alu_ctr(in_alu_ctr), .in_asrc(in_asrc), .in_bsrc(in_bsrc), .flush(flush),
    .exm_valid(exm_valid), .exm_wen(exm_wen), .exm_is_load(exm_is_load),
    .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .ex_is_load(ex_is_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Quiet bypass network and ID side.
  task automatic clear_inputs();
    in_valid = 0; in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_imm = '0; in_use_rs1 = 0; in_use_rs2 = 0; in_rd = '0; in_rd_wen = 0;
    in_is_load = 0; in_alu_ctr = '0; in_asrc = '0; in_bsrc = 0; flush = 0;
    exm_valid = 0; exm_wen = 0; exm_is_load = 0; exm_rd = '0; exm_result = '0;
    wb_valid = 0; wb_wen = 0; wb_rd = '0; wb_result = '0;
  endtask

  // Offer one instruction at a negedge; returns at the following negedge.
  task automatic push(input logic [DW-1:0] pc, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [DW-1:0] v1, input logic [DW-1:0] v2, input logic [DW-1:0] imm,
                      input logic u1, input logic u2, input logic [1:0] asrc, input logic bsrc);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = v1; in_rs2_val = v2;
    in_imm = imm; in_use_rs1 = u1; in_use_rs2 = u2; in_asrc = asrc; in_bsrc = bsrc;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
  endtask

  // Issue whatever is held and return idle at a negedge.
  task automatic drain();
    clear_inputs();
    out_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (alu_a !== '0 || alu_b !== '0) begin failures++; $display("FAIL reset_alu got a=%h b=%h want 0", alu_a, alu_b); end
    checks++; if (alu_ctr !== 4'b0 || ex_pc !== '0 || ex_rd !== '0 || ex_rd_wen !== 0 || ex_is_load !== 0)
      begin failures++; $display("FAIL reset_ex got ctr=%h pc=%h rd=%h", alu_ctr, ex_pc, ex_rd); end
    @(negedge clk); @(negedge clk);
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 0;
    in_rd = 5; in_rd_wen = 1; in_alu_ctr = 4'h3;
    push(32'h100, 5'd1, 5'd0, 32'h3, 32'h0, 32'd7, 1'b1, 1'b0, 2'd0, 1'b1);
    #1;
    checks++; if (out_valid !== 1 || alu_b !== 32'd7 || ex_rd !== 5'd5 || ex_rd_wen !== 1 || alu_ctr !== 4'h3)
      begin failures++; $display("FAIL addi_held got v=%b b=%h rd=%h ctr=%h want 1 7 5 3", out_valid, alu_b, ex_rd, alu_ctr); end
    #1 rst = 1;
    #1;
    checks++; if (out_valid !== 0 || alu_b !== '0 || ex_rd !== '0)
      begin failures++; $display("FAIL async_reset got v=%b b=%h rd=%h want 0 0 0", out_valid, alu_b, ex_rd); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (in_ready !== 1 || out_valid !== 0)
      begin failures++; $display("FAIL post_reset got rdy=%b v=%b want 1 0", in_ready, out_valid); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_priority();
    out_ready = 0;
    push(32'h200, 5'd1, 5'd2, 32'h99, 32'h5, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0);
    exm_valid = 1; exm_wen = 1; exm_rd = 1; exm_result = 32'h10;
    wb_valid = 1;  wb_wen = 1;  wb_rd = 1;  wb_result = 32'h20;
    #1;
    checks++; if (alu_a !== 32'h10 || alu_b !== 32'h5)
      begin failures++; $display("FAIL fwd_priority got a=%h b=%h want 10 5", alu_a, alu_b); end
    exm_valid = 0;
    #1;
    checks++; if (alu_a !== 32'h20) begin failures++; $display("FAIL fwd_wb got a=%h want 20", alu_a); end
    exm_valid = 1; exm_is_load = 1; exm_rd = 2;
    #1;
    checks++; if (alu_a !== 32'h20 || out_valid !== 0)
      begin failures++; $display("FAIL load_not_forwarded got a=%h v=%b want 20 0", alu_a, out_valid); end
    clear_inputs();
    #1;
    checks++; if (alu_a !== 32'h99 || out_valid !== 1)
      begin failures++; $display("FAIL stored_value got a=%h v=%b want 99 1", alu_a, out_valid); end
    drain();
  endtask

  task automatic test_x0();
    out_ready = 0;
    push(32'h300, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 2'd0, 1'b0);
    exm_valid = 1; exm_wen = 1; exm_rd = 0; exm_result = 32'hFFFF;
    wb_valid = 1; wb_wen = 1; wb_rd = 0; wb_result = 32'h1234;
    #1;
    checks++; if (alu_a !== '0 || alu_b !== '0)
      begin failures++; $display("FAIL x0_forward got a=%h b=%h want 0 0", alu_a, alu_b); end
    drain();
  endtask

  task automatic test_load_use();
    out_ready = 1;
    push(32'h400, 5'd4, 5'd0, 32'h1111, 32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    exm_valid = 1; exm_wen = 1; exm_is_load = 1; exm_rd = 4;
    #1;
    checks++; if (out_valid !== 0 || in_ready !== 0)
      begin failures++; $display("FAIL load_use_bubble got v=%b rdy=%b want 0 0", out_valid, in_ready); end
    @(negedge clk);
    clear_inputs();
    wb_valid = 1; wb_wen = 1; wb_rd = 4; wb_result = 32'hABCD;
    #1;
    checks++; if (out_valid !== 1 || alu_a !== 32'hABCD || ex_pc !== 32'h400)
      begin failures++; $display("FAIL load_use_resolve got v=%b a=%h pc=%h want 1 abcd 400", out_valid, alu_a, ex_pc); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (out_valid !== 0) begin failures++; $display("FAIL load_use_issued got v=%b want 0", out_valid); end
    // Source not read: no bubble even though indices match.
    out_ready = 0;
    push(32'h410, 5'd4, 5'd0, 32'h1, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    exm_valid = 1; exm_wen = 1; exm_is_load = 1; exm_rd = 4;
    #1;
    checks++; if (out_valid !== 1) begin failures++; $display("FAIL unused_src_no_bubble got v=%b want 1", out_valid); end
    drain();
  endtask

  task automatic test_sticky();
    out_ready = 0;
    push(32'h500, 5'd0, 5'd6, 32'h0, 32'h11, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    wb_valid = 1; wb_wen = 1; wb_rd = 6; wb_result = 32'h55;
    #1;
    checks++; if (alu_b !== 32'h55) begin failures++; $display("FAIL sticky_fwd got b=%h want 55", alu_b); end
    @(negedge clk);
    wb_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (alu_b !== 32'h55 || ex_store_data !== 32'h55 || out_valid !== 1)
        begin failures++; $display("FAIL sticky_hold%0d got b=%h sd=%h v=%b want 55 55 1", i, alu_b, ex_store_data, out_valid); end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    checks++; if (alu_b !== 32'h55) begin failures++; $display("FAIL sticky_issue got b=%h want 55", alu_b); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 0) begin failures++; $display("FAIL sticky_fired got v=%b want 0", out_valid); end
    out_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    // Held instruction stalled, flush with an offered one.
    out_ready = 0;
    push(32'h600, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    in_valid = 1; in_pc = 32'h700; flush = 1;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (out_valid !== 0 || ex_pc === 32'h700)
      begin failures++; $display("FAIL flush_stalled got v=%b pc=%h want 0 !700", out_valid, ex_pc); end
    // Held instruction issuing, so the incoming one would otherwise be accepted.
    push(32'h610, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
    out_ready = 1; in_valid = 1; in_pc = 32'h710; flush = 1;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (out_valid !== 0 || ex_pc === 32'h710)
      begin failures++; $display("FAIL flush_accept got v=%b pc=%h want 0 !710", out_valid, ex_pc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_pc [3];
    logic [DW-1:0] exp_a  [3];
    exp_pc[0] = 32'h800; exp_pc[1] = 32'h804; exp_pc[2] = 32'h808;
    exp_a[0]  = 32'h800; exp_a[1]  = 32'h0;   exp_a[2]  = 32'h0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = exp_pc[i]; in_rs1 = 5'd9; in_rs1_val = 32'hDEAD;
      in_asrc = 2'(i + 1); in_alu_ctr = 4'(i + 1); in_rd = 5'(i + 10);
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1 || ex_pc !== exp_pc[i] || alu_a !== exp_a[i] || alu_ctr !== 4'(i + 1) || ex_rd !== 5'(i + 10) || in_ready !== 1)
        begin failures++; $display("FAIL stream%0d got v=%b pc=%h a=%h ctr=%h rd=%h rdy=%b want pc=%h a=%h",
                                  i, out_valid, ex_pc, alu_a, alu_ctr, ex_rd, in_ready, exp_pc[i], exp_a[i]); end
    end
    clear_inputs();
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 0) begin failures++; $display("FAIL stream_end got v=%b want 0", out_valid); end
    out_ready = 0;
  endtask

  initial begin
    rst = 0;
    out_ready = 0;
    clear_inputs();
    #2 rst = 1;
    test_reset();
    test_reset_mid_hold();
    test_priority();
    test_x0();
    test_load_use();
    test_sticky();
    test_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID→EX pipeline register of the 5-stage core; feeds ALU operands A/B and the 4-bit ALU control directly.
- Latches decoded instructions under a valid/ready handshake and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Inserts load-use bubbles and honours branch flushes.
- Stored operands are refreshed from the bypass network every cycle an instruction is held, so a stalled instruction never loses a forwarded value.

Parameters:
- DATA_WIDTH, 32, datapath / operand width
- REG_AW, 5, register index width

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ID offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  DATA_WIDTH  instruction PC
- in_rs1, in_rs2  in  REG_AW  source indices
- in_rs1_val, in_rs2_val  in  DATA_WIDTH  regfile read data
- in_imm  in  DATA_WIDTH  sign-extended immediate
- in_use_rs1, in_use_rs2  in  1  source actually read
- in_rd  in  REG_AW  destination index
- in_rd_wen  in  1  writes rd
- in_is_load  in  1  load instruction
- in_alu_ctr  in  4  ALU operation code
- in_asrc  in  2  A select: 0=rs1, 1=pc, 2/3=zero
- in_bsrc  in  1  B select: 0=rs2, 1=imm
- flush  in  1  kill held and incoming instruction
- exm_valid, exm_wen, exm_is_load  in  1  EX/MEM producer status
- exm_rd  in  REG_AW  EX/MEM destination index
- exm_result  in  DATA_WIDTH  EX/MEM result
- wb_valid, wb_wen  in  1  MEM/WB producer status
- wb_rd  in  REG_AW  MEM/WB destination index
- wb_result  in  DATA_WIDTH  MEM/WB write-back data
- out_valid  out  1  EX holds a ready-to-issue instruction
- out_ready  in  1  EX/MEM consumes it
- alu_a, alu_b  out  DATA_WIDTH  ALU operands
- alu_ctr  out  4  ALU control
- ex_pc  out  DATA_WIDTH  PC of held instruction
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value
- ex_rd  out  REG_AW  destination index
- ex_rd_wen, ex_is_load  out  1  write / load flags

Behaviour:
- Reset (async, rst=1): held-valid flag and all payload registers cleared to 0. Outputs during reset: out_valid=0, alu_a=alu_b=0, alu_ctr=4'b0000, ex_*=0. in_ready=1 once reset is released.
- Forward select per source s (rs1, rs2), priority high to low:
  - EX/MEM match: exm_valid & exm_wen & exm_rd==s & s!=0 & !exm_is_load → exm_result.
  - MEM/WB match: wb_valid & wb_wen & wb_rd==s & s!=0 → wb_result.
  - Otherwise the stored value.
  - Index 0 is never forwarded.
- Load-use hazard: a held instruction with in_use_sX and exm_valid & exm_wen & exm_is_load & exm_rd==sX & sX!=0 forces out_valid=0 for that cycle. Payload is held. Resolves when the load reaches MEM/WB and is caught by WB forwarding.
- out_valid = held_valid & !load_use.
- alu_a:
  - asrc 0 → fwd_rs1.
  - asrc 1 → ex_pc.
  - asrc 2/3 → 0.
- alu_b: bsrc 0 → fwd_rs2; bsrc 1 → imm.
- ex_store_data = fwd_rs2.
- All outputs are combinational from the registers plus the bypass inputs; no added latency.
- Handshake:
  - fire_out = out_valid & out_ready.
  - in_ready = !held_valid | fire_out.
  - fire_in = in_valid & in_ready & !flush.
- Register update each edge:
  - flush: held_valid←0; incoming instruction discarded. Flush dominates fire_in and the stall.
  - else if fire_in: load all payload from in_*; held_valid←1. Back-to-back issue at 1 instr/cycle.
  - else if fire_out: held_valid←0.
  - else if held_valid: rs1_val←fwd_rs1, rs2_val←fwd_rs2 (sticky refresh); other payload unchanged.
- Operand rules:
  - in_use_sX=0 disables the load-use check for that source.
  - Forwarding still applies to alu_* regardless of in_use_sX; this is harmless because the value is unused.
- No arithmetic is performed in this block; all values are passed at full DATA_WIDTH.

Test Plan:
- Reset mid-hold:
  - Stimulus: accept addi (in_rd=5, imm=7, in_bsrc=1), hold with out_ready=0, then assert rst asynchronously.
  - Required: out_valid=0 and alu_b=0 immediately, before the next edge; in_ready=1 after release.
- EX/MEM vs MEM/WB priority:
  - Stimulus: add x3,x1,x2 with exm (rd=1, result=0x10) and wb (rd=1, result=0x20) both matching; rs2_val=5.
  - Required: alu_a=0x10, alu_b=5.
- x0 never forwarded:
  - Stimulus: rs1=0, rs1_val=0, exm_rd=0 with exm_wen=1, exm_result=0xFFFF.
  - Required: alu_a=0.
- Load-use bubble:
  - Cycle 0: held instruction uses rs1=4; exm is a load to x4; out_valid=0 and in_ready=0.
  - Next cycle: load moves to wb (wb_rd=4, wb_result=0xABCD); out_valid=1 and alu_a=0xABCD.
  - Required: after fire, 0xABCD is the value issued.
- Sticky refresh under stall:
  - Stimulus: out_ready=0; wb forwards 0x55 to rs2 for 1 cycle, then wb_valid=0.
  - Required: alu_b=0x55 and ex_store_data=0x55 persist until fire_out.
- Flush vs. simultaneous accept:
  - Stimulus: flush=1 with in_valid=1 and held_valid=1.
  - Required: next cycle out_valid=0 and the incoming PC never appears on ex_pc.
  - Then stream 3 instructions with out_ready=1: one issued per cycle, in order.
